ram_arbiter: RTL
================

# ram_arbiter

Round-robin arbiter that shares the single-port line-fill `ram` between `NUM_REQ` cache refill requesters (I-cache and D-cache refill engines by default). It serialises line requests, presents one aligned address to the RAM, holds it stable until the RAM answers, and routes the 512-bit line back to the granted requester. A watchdog turns a lost RAM response into an error response, so no requester hangs.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_W`, 32: byte address width.
- `LINE_W`, 512: line width in bits (64 bytes).
- `TIMEOUT`, 255: maximum number of WAIT cycles before an error response, 1..255.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester line request.
- `req_addr` in NUM_REQ*ADDR_W: packed byte addresses; slice i belongs to requester i.
- `req_ack` out NUM_REQ: one-cycle pulse when request i is accepted.
- `resp_valid` out NUM_REQ: one-cycle pulse when the line for requester i is returned.
- `resp_err` out 1: qualifies `resp_valid`; 1 means timeout, and `resp_data` is zero.
- `resp_data` out LINE_W: returned line; held until the next response.
- `mem_req` out 1: request to `ram`.
- `mem_addr` out ADDR_W: line-aligned address to `ram`; held from issue until the response.
- `mem_data` in LINE_W: `ram` data_out.
- `mem_ready` in 1: `ram` ready pulse.
- `busy` out 1: high in ISSUE and WAIT.
- `timeout_cnt` out 8: saturating count of timeouts.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:** the round-robin picker selects the first i with `req_valid[i]`, searching from `(last_grant+1) mod NUM_REQ`.
  - If any request is present, the arbiter registers `grant=i`, pulses `req_ack[i]` and latches `mem_addr = req_addr[i]` with the low log2(LINE_W/8) bits cleared.
  - It then moves to ISSUE and sets `last_grant=i`.
- **ISSUE:** `mem_req=1` for exactly this one cycle, then the FSM moves to WAIT. The watchdog counter is cleared.
- **WAIT:** `mem_req=0`; the watchdog counter increments each cycle.
  - On `mem_ready=1`: register `resp_data<=mem_data`, `resp_err<=0`, pulse `resp_valid[grant]`, go to IDLE.
  - Else, if the counter reaches TIMEOUT: `resp_data<=0`, `resp_err<=1`, pulse `resp_valid[grant]`, increment `timeout_cnt` (saturating at 255), go to IDLE.
  - If `mem_ready` arrives on the same cycle the counter reaches TIMEOUT, `mem_ready` wins and the response is not an error.
- `mem_ready` while in IDLE or ISSUE is ignored: no response is generated and no state changes.
- Requester rules:
  - A requester holds `req_valid` and `req_addr` stable until `req_ack`.
  - `req_valid` sampled in ISSUE or WAIT has no effect.
  - A requester may re-raise `req_valid` after `req_ack` and before its `resp_valid`. The new request is arbitrated normally once the FSM returns to IDLE.
- Only one transaction is in flight at a time.

## Timing
- All outputs are registered.
- Reset values: every output 0, FSM in IDLE, `last_grant=NUM_REQ-1` (requester 0 wins first), watchdog 0.
- Grant latency: `req_valid` sampled in IDLE at edge E gives `req_ack` and `mem_addr` valid in cycle E+1. `mem_req` is high in cycle E+1 and is sampled by `ram` at edge E+2.
- RAM latency is 101 cycles from the sampled `mem_req` to `mem_ready`. The requester sees `resp_valid` in the cycle after `mem_ready`.
- Back-to-back transactions:
  - The FSM is in IDLE in the cycle `resp_valid` is high.
  - The next `req_ack`/`mem_req` follows one cycle later.
  - `ram` is idle by then, because its ready pulse already cleared its busy flag.
- Reset asserted mid-transaction aborts immediately:
  - Outputs clear, the pending response is lost, and no `resp_valid` is produced.
  - `ram` shares the system reset and is aborted with it.

## Structure
- Package `ram_arb_pkg`:
  - the state enum (IDLE/ISSUE/WAIT);
  - `LINE_BYTES = LINE_W/8`;
  - `OFFSET_W = $clog2(LINE_BYTES)`;
  - the watchdog width constant (8).
- Sub-module `rr_picker`: combinational; inputs `req_valid` and `last_grant`; outputs `any` and `idx`. It is reusable by future multi-port controllers.
- The FSM, watchdog and data register live in `ram_arbiter`.

## Test plan
- **Reset, then single request:** `req_valid[0]=1`, `addr=0x0000_1234`.
  - `req_ack[0]` on the next cycle, `mem_addr=0x0000_1200`, `mem_req` high for 1 cycle.
  - `resp_valid[0]` with `resp_err=0` and `resp_data` equal to the `ram` line for `0x1200`.
- **Simultaneous requests:** `req_valid=2'b11` after reset.
  - Requester 0 is served first, then requester 1.
  - Holding both asserted alternates 0,1,0,1 across four transactions.
- **Address stability:** change `req_addr[1]` after `req_ack[1]`.
  - `mem_addr` is unchanged until `resp_valid[1]`.
  - The returned data matches the originally latched address.
- **Timeout:** the stub memory never asserts ready, `TIMEOUT=20`.
  - `resp_valid` exactly 20 WAIT cycles after ISSUE, with `resp_err=1` and `resp_data=0`.
  - `timeout_cnt=1`.
- **Ready/timeout tie and stray ready:** ready on the TIMEOUT cycle gives `resp_err=0`. `mem_ready` pulsed in IDLE gives no `resp_valid`.
- **Reset mid-WAIT:** at cycle 50 of WAIT, drop `rst` for 2 cycles.
  - All outputs are 0 and no response follows.
  - A fresh request completes normally.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the line-fill RAM arbiter and its
// round-robin picker.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int LINE_W_DEF = 512;
  localparam int LINE_BYTES = LINE_W_DEF / 8;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int WDOG_W     = 8;

  // Byte-offset bits inside a line of the given width.
  function automatic int offset_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after last_grant,
// wrapping around to index 0.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output gets a default before the loops so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && req_valid[i] && (i > int'(last_grant))) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req_valid[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port line-fill RAM between refill
// requesters, with a watchdog that converts a lost RAM response into an error.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 512,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_err,
  output logic [LINE_W-1:0]         resp_data,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [LINE_W-1:0]         mem_data,
  input  logic                      mem_ready,
  output logic                      busy,
  output logic [WDOG_W-1:0]         timeout_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int OFF_W = offset_bits(LINE_W);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [WDOG_W-1:0]  tcnt_q, tcnt_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_req_q, mem_req_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] rv_q, rv_d;
  logic               err_q, err_d;
  logic [LINE_W-1:0]  data_q, data_d;
  logic               busy_q, busy_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_valid  (req_valid),
    .last_grant (last_q),
    .any        (pick_any),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    wdog_d     = wdog_q;
    tcnt_d     = tcnt_q;
    mem_addr_d = mem_addr_q;
    err_d      = err_q;
    data_d     = data_q;
    busy_d     = busy_q;
    mem_req_d  = 1'b0;
    ack_d      = '0;
    rv_d       = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          last_d     = pick_idx;
          ack_d      = NUM_REQ'(1) << pick_idx;
          mem_addr_d = {addr_arr[pick_idx][ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A ready arriving on the expiry cycle still delivers real data.
        if (mem_ready) begin
          data_d  = mem_data;
          err_d   = 1'b0;
          rv_d    = NUM_REQ'(1) << grant_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (wdog_d == WDOG_W'(TIMEOUT)) begin
          data_d  = '0;
          err_d   = 1'b1;
          rv_d    = NUM_REQ'(1) << grant_q;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (tcnt_q != '1) tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
      wdog_q     <= '0;
      tcnt_q     <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      ack_q      <= '0;
      rv_q       <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wdog_q     <= wdog_d;
      tcnt_q     <= tcnt_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      ack_q      <= ack_d;
      rv_q       <= rv_d;
      err_q      <= err_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ack     = ack_q;
  assign resp_valid  = rv_q;
  assign resp_err    = err_q;
  assign resp_data   = data_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign busy        = busy_q;
  assign timeout_cnt = tcnt_q;

endmodule
